// File: rtl/vqc_gate_sequencer.sv
// vqc_gate_sequencer: applies a programmed chain of 4x4 complex gate matrices to a
// 2-qubit state vector, one complex multiply-accumulate per cycle.
// The host loads the matrix bank, the program and the initial state while the block is
// idle. A start request then runs the program and leaves the result on psi_f.
module vqc_gate_sequencer #(
  parameter int N          = 16,
  parameter int FRAC       = 14,
  parameter int MAT_SLOTS  = 8,
  parameter int PROG_DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_we,
  input  logic [1:0]   cfg_sel,
  input  logic [7:0]   cfg_addr,
  input  logic [N-1:0] cfg_wdata,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] psi_f [0:7]
);

  localparam int SLOT_W    = (MAT_SLOTS > 1) ? $clog2(MAT_SLOTS) : 1;
  localparam int PC_W      = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;
  localparam int ACC_W     = 2 * N + 3;
  localparam int MAT_WORDS = MAT_SLOTS * 32;

  localparam logic [N-1:0]              ONE_Q   = N'(2 ** FRAC);
  localparam logic signed [ACC_W-1:0]   SAT_MAX = {{(ACC_W - N + 1){1'b0}}, {(N - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0]   SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_MAC,
    S_WB,
    S_DONE
  } state_e;

  // Host-visible memories, deliberately left without reset
  logic [N-1:0]    mat_mem  [0:MAT_WORDS-1];
  logic [SLOT_W:0] prog_mem [0:PROG_DEPTH-1];
  logic [N-1:0]    init_mem [0:7];

  state_e                  state_q, state_d;
  logic [PC_W-1:0]         pc_q, pc_d;
  logic [3:0]              j_q, j_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic                    last_q, last_d;
  logic signed [ACC_W-1:0] acc_re_q [0:3];
  logic signed [ACC_W-1:0] acc_re_d [0:3];
  logic signed [ACC_W-1:0] acc_im_q [0:3];
  logic signed [ACC_W-1:0] acc_im_d [0:3];
  logic [N-1:0]            psi_q [0:7];
  logic [N-1:0]            psi_d [0:7];

  logic                    cfg_ok;
  logic                    mat_wr_ok;
  logic                    prog_wr_ok;
  logic                    pc_last;
  logic                    slot_ok;
  logic [1:0]              r_idx;
  logic [1:0]              c_idx;
  logic [N-1:0]            m_re;
  logic [N-1:0]            m_im;
  logic [N-1:0]            b_re;
  logic [N-1:0]            b_im;
  logic signed [2*N-1:0]   p_rr;
  logic signed [2*N-1:0]   p_ii;
  logic signed [2*N-1:0]   p_ri;
  logic signed [2*N-1:0]   p_ir;
  logic signed [ACC_W-1:0] prod_re;
  logic signed [ACC_W-1:0] prod_im;
  logic [SLOT_W:0]         prog_word;

  // Scale back from the product format, rounding toward -inf, and clamp to N bits
  function automatic logic [N-1:0] sat_n(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> FRAC;
    if (s > SAT_MAX) begin
      return SAT_MAX[N-1:0];
    end else if (s < SAT_MIN) begin
      return SAT_MIN[N-1:0];
    end
    return s[N-1:0];
  endfunction

  assign cfg_ok     = cfg_we && (state_q == S_IDLE);
  assign mat_wr_ok  = 32'(cfg_addr[SLOT_W+4:5]) < MAT_SLOTS;
  assign prog_wr_ok = 32'(cfg_addr) < PROG_DEPTH;
  assign pc_last    = 32'(pc_q) == (PROG_DEPTH - 1);

  // Host configuration writes, accepted only while idle
  always_ff @(posedge clk) begin
    if (cfg_ok) begin
      case (cfg_sel)
        2'd0: if (mat_wr_ok) mat_mem[cfg_addr[SLOT_W+4:0]] <= cfg_wdata;
        2'd1: if (prog_wr_ok) prog_mem[cfg_addr[PC_W-1:0]] <= {cfg_wdata[N-1], cfg_wdata[SLOT_W-1:0]};
        2'd2: init_mem[cfg_addr[2:0]] <= cfg_wdata;
        default: ;
      endcase
    end
  end

  // State register and datapath flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      j_q      <= '0;
      slot_q   <= '0;
      last_q   <= 1'b0;
      acc_re_q <= '{default: '0};
      acc_im_q <= '{default: '0};
      psi_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      j_q      <= j_d;
      slot_q   <= slot_d;
      last_q   <= last_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      psi_q    <= psi_d;
    end
  end

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  state_d = S_FETCH;
      S_FETCH: state_d = S_MAC;
      S_MAC:   if (j_q == 4'd15) state_d = S_WB;
      S_WB:    state_d = (last_q || pc_last) ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Complex MAC operands for the current matrix entry; out-of-range slots act as identity
  always_comb begin
    r_idx   = j_q[3:2];
    c_idx   = j_q[1:0];
    slot_ok = 32'(slot_q) < MAT_SLOTS;
    if (slot_ok) begin
      m_re = mat_mem[{slot_q, j_q, 1'b0}];
      m_im = mat_mem[{slot_q, j_q, 1'b1}];
    end else begin
      m_re = (r_idx == c_idx) ? ONE_Q : '0;
      m_im = '0;
    end
    b_re    = psi_q[{c_idx, 1'b0}];
    b_im    = psi_q[{c_idx, 1'b1}];
    p_rr    = $signed(m_re) * $signed(b_re);
    p_ii    = $signed(m_im) * $signed(b_im);
    p_ri    = $signed(m_re) * $signed(b_im);
    p_ir    = $signed(m_im) * $signed(b_re);
    prod_re = ACC_W'(p_rr) - ACC_W'(p_ii);
    prod_im = ACC_W'(p_ri) + ACC_W'(p_ir);
  end

  // Output decode and per-state register updates
  always_comb begin
    pc_d      = pc_q;
    j_d       = j_q;
    slot_d    = slot_q;
    last_d    = last_q;
    acc_re_d  = acc_re_q;
    acc_im_d  = acc_im_q;
    psi_d     = psi_q;
    prog_word = prog_mem[pc_q];
    busy      = (state_q == S_LOAD) || (state_q == S_FETCH) ||
                (state_q == S_MAC)  || (state_q == S_WB);
    done      = (state_q == S_DONE);
    case (state_q)
      S_LOAD: begin
        psi_d    = init_mem;
        pc_d     = '0;
        acc_re_d = '{default: '0};
        acc_im_d = '{default: '0};
      end
      S_FETCH: begin
        slot_d = prog_word[SLOT_W-1:0];
        last_d = prog_word[SLOT_W];
        j_d    = '0;
      end
      S_MAC: begin
        acc_re_d[r_idx] = acc_re_q[r_idx] + prod_re;
        acc_im_d[r_idx] = acc_im_q[r_idx] + prod_im;
        j_d             = j_q + 4'd1;
      end
      S_WB: begin
        for (int unsigned k = 0; k < 4; k++) begin
          psi_d[3'(2 * k)]     = sat_n(acc_re_q[2'(k)]);
          psi_d[3'(2 * k + 1)] = sat_n(acc_im_q[2'(k)]);
        end
        acc_re_d = '{default: '0};
        acc_im_d = '{default: '0};
        if (!(last_q || pc_last)) pc_d = pc_q + 1'b1;
      end
      default: ;
    endcase
  end

  assign psi_f = psi_q;

endmodule
